dev_timer: RTL and testbench
============================

# dev_timer

Programmable down-counting timer that sits on the device side of the processor-to-device bridge. It occupies the bridge's three-word device window: CTRL at offset 0, PRESET at offset 1 and COUNT at offset 2. It answers the bridge's word reads and writes and drives the single interrupt line that the bridge forwards to the CPU as `hwInt[0]`. It supports one-shot and auto-reload modes, with an optional clock prescaler.

## Interface
- `PRESCALE`, default 1: number of `clk` cycles per count step. Legal range is 1..65535.
- `clk` in 1: system clock. Every register updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `devAddr` in 2 (bits [3:2]): word select. 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = unused.
- `devWe` in 1: write strobe, qualified by the bridge. A write commits on the edge at which `devWe` is 1.
- `devWd` in 32: write data.
- `devRd` out 32: read data, combinational from `devAddr`.
- `irq` out 1: interrupt request, level output from a register, gated by the IM bit.

## Operation
- CTRL register, 4 bits; bits [31:4] read as 0.
  - [0] EN: enable.
  - [2:1] MODE: 00 = one-shot, 01 = auto-reload. 10 and 11 behave as 00.
  - [3] IM: interrupt mask, where 1 enables `irq`.
- PRESET: 32-bit read/write. A write takes effect at the next LOAD. Running counts are not restarted.
- COUNT: 32-bit, read-only. Writes to offset 2 and offset 3 are ignored. Offset 3 reads 0.
- `irq` = IRQF & CTRL.IM. IRQF is an internal flag.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN = 1, go to LOAD. Otherwise stay. COUNT holds its value.
  - LOAD:
    - COUNT ← PRESET.
    - Prescaler ← 0.
    - If EN = 0, go to IDLE. Otherwise go to CNT.
  - CNT:
    - If EN = 0, go to IDLE with COUNT held.
    - Otherwise, on a prescaler tick: if COUNT ≤ 1, set COUNT ← 0, IRQF ← 1 and go to INT. Else COUNT ← COUNT − 1.
    - With no tick, nothing changes.
  - INT, MODE one-shot: EN ← 0, go to IDLE. IRQF stays set.
  - INT, MODE auto-reload: IRQF ← 0, go to LOAD.
- IRQF clears on any write to CTRL or PRESET. It also clears on the INT→LOAD transition.
- Prescaler tick: a counter runs 0..PRESCALE−1 while in CNT. A tick occurs when the counter equals PRESCALE−1, and the counter then wraps to 0. With PRESCALE = 1 every CNT cycle is a tick.
- Simultaneous events:
  - A CTRL write on the same edge as the one-shot EN clear in INT: the written value wins.
  - A CTRL write on the same edge that sets IRQF in CNT: the flag clear wins, so IRQF = 0.
  - A PRESET write on the same edge as LOAD: LOAD takes the old PRESET.
- Preset 0 behaves as preset 1: INT is reached on the first tick.
- The counter never goes below 0, so there is no wrap-around.

## Timing
- Reset values: CTRL = 0, PRESET = 0, COUNT = 0, prescaler = 0, IRQF = 0, state = IDLE. Outputs: `irq` = 0, and `devRd` = 0 for every address.
- Reset asserted mid-count forces the reset values immediately, without waiting for `clk`.
- Read latency is 0 cycles: `devRd` reflects register state after the most recent edge.
- Example with PRESCALE = 1, PRESET = N ≥ 1, and EN written on edge E0:
  - E1: state goes to LOAD.
  - E2: COUNT = N, state CNT.
  - E(2+N): COUNT = 0, IRQF = 1, state INT.
  - `irq` is high from E(2+N) if IM = 1.
- Auto-reload: the INT→LOAD→CNT loop gives a period of N+2 cycles. `irq` is high for exactly 1 cycle per period.
- One-shot: `irq` stays high until software writes CTRL or PRESET.
- With PRESCALE = P, each decrement takes P cycles in CNT.

## Structure
- Package `timer_pkg` holds:
  - address constants: ADDR_CTRL = 0, ADDR_PRESET = 1, ADDR_COUNT = 2;
  - state encodings: IDLE, LOAD, CNT, INT;
  - MODE codes;
  - CTRL bit positions: EN, MODE, IM.
- Sub-module `timer_prescaler`: inputs are clock, reset, a clear signal and a run signal; output is a 1-cycle tick. It is parameterised by PRESCALE.
- The register file, FSM and read mux live in `dev_timer`.

## Test plan
- Reset with writes idle: all reads at offsets 0–3 return 0, and `irq` = 0. Assert `rst` low in the middle of a count: COUNT, `irq` and CTRL go to 0 immediately.
- One-shot, PRESCALE = 1: write PRESET = 3, then CTRL = 0x9. COUNT reads 3, 2, 1, 0 on successive cycles after LOAD. `irq` rises 5 cycles after the CTRL write edge. CTRL then reads 0x8. `irq` holds until CTRL is written with 0, then drops on the next edge.
- Auto-reload: PRESET = 4, CTRL = 0xB. `irq` gives 1-cycle pulses every 6 cycles across at least 3 periods. With IM = 0 (CTRL = 0x3), COUNT still cycles and `irq` stays 0.
- Disable mid-count: PRESET = 10, enable, then write CTRL = 0 when COUNT = 6. COUNT holds at 6 and `irq` stays 0. Re-enabling reloads 10.
- PRESCALE = 4, PRESET = 2, one-shot: each decrement takes 4 cycles, and `irq` rises 10 cycles after the CTRL write edge.
- Collision cases:
  - A write to offset 2 or 3 leaves COUNT unchanged.
  - A PRESET write in the same cycle as LOAD loads the old value.
  - A CTRL write on the IRQF-set edge leaves `irq` = 0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared constants and types for the device-side programmable timer:
// register offsets, FSM encodings, MODE codes and CTRL bit layout.
package timer_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } timerState_t;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } timerCtrl_t;

  // Codes 10 and 11 fall back to one-shot, so only 01 reloads.
  function automatic logic isReload(input logic [1:0] mode);
    return (mode == MODE_RELOAD);
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Count-step prescaler: emits a one-cycle tick every PRESCALE cycles of run,
// restarting from zero whenever clear is asserted.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] psCount;

  assign tick = run && (psCount == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      psCount <= '0;
    end else if (clear) begin
      psCount <= '0;
    end else if (run) begin
      psCount <= tick ? 16'd0 : psCount + 16'd1;
    end
  end

endmodule

// File: rtl/dev_timer.sv
// Programmable down-counting timer in the bridge's three-word device window
// (CTRL, PRESET, COUNT) with one-shot / auto-reload modes and a masked irq.
module dev_timer
  import timer_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  devAddr,
  input  logic        devWe,
  input  logic [31:0] devWd,
  output logic [31:0] devRd,
  output logic        irq,
  output logic [1:0]  dbgState
);

  // Bus handshake: a write commits on every rising edge where devWe is 1,
  // there is no ready/stall; reads are combinational from devAddr.

  timerState_t state;
  timerCtrl_t  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irqf;
  logic        tick;
  logic        wrCtrl;
  logic        wrPreset;

  assign wrCtrl   = devWe && (devAddr == ADDR_CTRL);
  assign wrPreset = devWe && (devAddr == ADDR_PRESET);

  timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (state == LOAD),
    .run   ((state == CNT) && ctrl.en),
    .tick  (tick)
  );

  // PRESET is only sampled in LOAD, so a write on the LOAD edge is seen next time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      preset <= '0;
    end else if (wrPreset) begin
      preset <= devWd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ctrl  <= '0;
      count <= '0;
      irqf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ctrl.en) state <= LOAD;
        end
        LOAD: begin
          count <= preset;
          state <= ctrl.en ? CNT : IDLE;
        end
        CNT: begin
          if (!ctrl.en) begin
            state <= IDLE;
          end else if (tick) begin
            // A preset of 0 lands here on the first tick just like a preset of 1.
            if (count <= 32'd1) begin
              count <= '0;
              irqf  <= 1'b1;
              state <= INT;
            end else begin
              count <= count - 32'd1;
            end
          end
        end
        INT: begin
          if (isReload(ctrl.mode)) begin
            irqf  <= 1'b0;
            state <= LOAD;
          end else begin
            ctrl.en <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Software writes are placed last so they override same-edge FSM updates.
      if (wrCtrl) ctrl <= timerCtrl_t'(devWd[3:0]);
      if (wrCtrl || wrPreset) irqf <= 1'b0;
    end
  end

  always_comb begin
    devRd = '0;
    case (devAddr)
      ADDR_CTRL:   devRd = {28'd0, ctrl};
      ADDR_PRESET: devRd = preset;
      ADDR_COUNT:  devRd = count;
      default:     devRd = '0;
    endcase
  end

  assign irq      = irqf & ctrl.im;
  assign dbgState = state;

endmodule

// File: tb/tb_dev_timer.sv
// Bench for dev_timer: one instance with PRESCALE=1 and one with PRESCALE=4
// share the bus inputs; each scenario task checks its own expectations.
module tb_dev_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  devAddr = 2'd0;
  logic        devWe = 1'b0;
  logic [31:0] devWd = 32'd0;
  logic [31:0] devRd, devRd4;
  logic        irq, irq4;
  logic [1:0]  dbgState, dbgState4;

  int total = 0;
  int bad = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  dev_timer #(.PRESCALE(1)) u_dut (
    .clk(clk), .rst(rst), .devAddr(devAddr), .devWe(devWe), .devWd(devWd),
    .devRd(devRd), .irq(irq), .dbgState(dbgState)
  );

  dev_timer #(.PRESCALE(4)) u_dut4 (
    .clk(clk), .rst(rst), .devAddr(devAddr), .devWe(devWe), .devWd(devWd),
    .devRd(devRd4), .irq(irq4), .dbgState(dbgState4)
  );

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    devAddr = a;
    devWd   = d;
    devWe   = 1'b1;
    @(posedge clk);
    #1;
    devWe = 1'b0;
    devWd = 32'd0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    devAddr = a;
    #1;
    d = devRd;
  endtask

  task automatic rd4(input logic [1:0] a, output logic [31:0] d);
    devAddr = a;
    #1;
    d = devRd4;
  endtask

  task automatic quiesce();
    wr(2'd0, 32'd0);
    repeat (3) cyc();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] v;
    #12;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      total++;
      if (v !== 32'd0) begin bad++; $display("FAIL reset_rd%0d got=%0h exp=0", a, v); end
      rd4(2'(a), v);
      total++;
      if (v !== 32'd0) begin bad++; $display("FAIL reset_rd4_%0d got=%0h exp=0", a, v); end
    end
    total++;
    if (irq !== 1'b0 || irq4 !== 1'b0) begin
      bad++; $display("FAIL reset_irq got=%b/%b exp=0/0", irq, irq4);
    end
    total++;
    if (dbgState !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbgState); end
    @(negedge clk);
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    logic [32:0] e;
    quiesce();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h9);
    for (int k = 2; k <= 5; k++) exp_q.push_back({(k == 5), 32'(5 - k)});
    cyc();
    total++;
    if (dbgState !== 2'd1) begin bad++; $display("FAIL oneshot_load got=%0d exp=1", dbgState); end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL oneshot_irq_e1 got=%b exp=0", irq); end
    for (int k = 2; k <= 5; k++) begin
      cyc();
      e = exp_q.pop_front();
      rd(2'd2, v);
      total++;
      if ({irq, v} !== e) begin
        bad++; $display("FAIL oneshot_e%0d got=%b/%0d exp=%b/%0d", k, irq, v, e[32], e[31:0]);
      end
    end
    cyc();
    rd(2'd0, v);
    total++;
    if (v !== 32'h8) begin bad++; $display("FAIL oneshot_ctrl got=%0h exp=8", v); end
    repeat (3) cyc();
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL oneshot_hold got=%b exp=1", irq); end
    wr(2'd0, 32'd0);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL oneshot_clear got=%b exp=0", irq); end
  endtask

  task automatic test_autoreload();
    logic [31:0] v;
    logic [32:0] e;
    int p;
    quiesce();
    wr(2'd1, 32'd4);
    wr(2'd0, 32'hB);
    for (int k = 2; k <= 20; k++) begin
      p = (k - 2) % 6;
      exp_q.push_back({(p == 4), (p <= 3) ? 32'(4 - p) : 32'd0});
    end
    cyc();
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL reload_irq_e1 got=%b exp=0", irq); end
    for (int k = 2; k <= 20; k++) begin
      cyc();
      e = exp_q.pop_front();
      rd(2'd2, v);
      total++;
      if ({irq, v} !== e) begin
        bad++; $display("FAIL reload_e%0d got=%b/%0d exp=%b/%0d", k, irq, v, e[32], e[31:0]);
      end
    end
    quiesce();
    wr(2'd0, 32'h3);
    for (int k = 2; k <= 20; k++) begin
      p = (k - 2) % 6;
      exp_q.push_back({1'b0, (p <= 3) ? 32'(4 - p) : 32'd0});
    end
    cyc();
    for (int k = 2; k <= 20; k++) begin
      cyc();
      e = exp_q.pop_front();
      rd(2'd2, v);
      total++;
      if ({irq, v} !== e) begin
        bad++; $display("FAIL masked_e%0d got=%b/%0d exp=%b/%0d", k, irq, v, e[32], e[31:0]);
      end
    end
  endtask

  task automatic test_disable();
    logic [31:0] v;
    quiesce();
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    repeat (5) cyc();
    rd(2'd2, v);
    total++;
    if (v !== 32'd7) begin bad++; $display("FAIL disable_pre got=%0d exp=7", v); end
    wr(2'd0, 32'd0);
    for (int k = 0; k < 4; k++) begin
      rd(2'd2, v);
      total++;
      if (v !== 32'd6 || irq !== 1'b0) begin
        bad++; $display("FAIL disable_hold%0d got=%0d/%b exp=6/0", k, v, irq);
      end
      cyc();
    end
    total++;
    if (dbgState !== 2'd0) begin bad++; $display("FAIL disable_idle got=%0d exp=0", dbgState); end
    wr(2'd0, 32'h1);
    cyc();
    cyc();
    rd(2'd2, v);
    total++;
    if (v !== 32'd10) begin bad++; $display("FAIL disable_reload got=%0d exp=10", v); end
  endtask

  task automatic test_prescale();
    logic [31:0] v;
    logic [32:0] e;
    quiesce();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    for (int k = 2; k <= 10; k++)
      exp_q.push_back({(k == 10), (k < 6) ? 32'd2 : ((k < 10) ? 32'd1 : 32'd0)});
    cyc();
    for (int k = 2; k <= 10; k++) begin
      cyc();
      e = exp_q.pop_front();
      rd4(2'd2, v);
      total++;
      if ({irq4, v} !== e) begin
        bad++; $display("FAIL prescale_e%0d got=%b/%0d exp=%b/%0d", k, irq4, v, e[32], e[31:0]);
      end
    end
    cyc();
    rd4(2'd0, v);
    total++;
    if (v !== 32'h8 || irq4 !== 1'b1) begin
      bad++; $display("FAIL prescale_end got=%0h/%b exp=8/1", v, irq4);
    end
  endtask

  task automatic test_collisions();
    logic [31:0] v;
    // writes to COUNT and the unused word are dropped
    quiesce();
    wr(2'd1, 32'd8);
    wr(2'd0, 32'h1);
    cyc();
    cyc();
    wr(2'd2, 32'hdead);
    rd(2'd2, v);
    total++;
    if (v !== 32'd7) begin bad++; $display("FAIL wr_count got=%0h exp=7", v); end
    wr(2'd3, 32'hbeef);
    rd(2'd2, v);
    total++;
    if (v !== 32'd6) begin bad++; $display("FAIL wr_unused got=%0h exp=6", v); end
    rd(2'd3, v);
    total++;
    if (v !== 32'd0) begin bad++; $display("FAIL rd_unused got=%0h exp=0", v); end
    // PRESET written on the LOAD edge
    quiesce();
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h1);
    cyc();
    wr(2'd1, 32'd9);
    rd(2'd2, v);
    total++;
    if (v !== 32'd5) begin bad++; $display("FAIL load_old got=%0d exp=5", v); end
    rd(2'd1, v);
    total++;
    if (v !== 32'd9) begin bad++; $display("FAIL load_newpreset got=%0d exp=9", v); end
    // CTRL written on the IRQF-set edge
    quiesce();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h9);
    repeat (4) cyc();
    wr(2'd0, 32'h9);
    total++;
    if (irq !== 1'b0 || dbgState !== 2'd3) begin
      bad++; $display("FAIL irqf_race got=%b/%0d exp=0/3", irq, dbgState);
    end
    cyc();
    rd(2'd0, v);
    total++;
    if (irq !== 1'b0 || v !== 32'h8) begin
      bad++; $display("FAIL irqf_race_after got=%b/%0h exp=0/8", irq, v);
    end
    // PRESET 0 behaves as 1
    quiesce();
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    cyc();
    cyc();
    total++;
    if (irq !== 1'b0 || dbgState !== 2'd2) begin
      bad++; $display("FAIL preset0_cnt got=%b/%0d exp=0/2", irq, dbgState);
    end
    cyc();
    rd(2'd2, v);
    total++;
    if (irq !== 1'b1 || v !== 32'd0) begin
      bad++; $display("FAIL preset0_int got=%b/%0d exp=1/0", irq, v);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    logic [31:0] c;
    quiesce();
    wr(2'd1, 32'd20);
    wr(2'd0, 32'h9);
    repeat (5) cyc();
    rd(2'd2, v);
    total++;
    if (v !== 32'd17) begin bad++; $display("FAIL mid_pre got=%0d exp=17", v); end
    #2;
    rst = 1'b0;
    #1;
    rd(2'd2, v);
    rd(2'd0, c);
    total++;
    if (v !== 32'd0 || c !== 32'd0 || irq !== 1'b0 || dbgState !== 2'd0) begin
      bad++; $display("FAIL mid_reset got=%0d/%0h/%b/%0d exp=0/0/0/0", v, c, irq, dbgState);
    end
    @(negedge clk);
    rst = 1'b1;
    cyc();
    cyc();
    rd(2'd2, v);
    total++;
    if (v !== 32'd0 || dbgState !== 2'd0) begin
      bad++; $display("FAIL mid_after got=%0d/%0d exp=0/0", v, dbgState);
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_autoreload();
    test_disable();
    test_prescale();
    test_collisions();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
